// File: rtl/z_stream_deserializer_pkg.sv
// Shared types and defaults for the z-stream deserializer.
//   Contents: buffer state enum, default word width and match pattern.
package z_stream_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'hA5;

  // Output buffer occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/z_stream_deserializer_bit_shift_counter.sv
// Serial bit collector: MSB-first shift register, in-word bit counter and a
// saturating fill counter, all flushed by clr.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : synchronous flush (drops a bit accepted in the same cycle)
//   bit_in        : serial data
//   bit_valid     : bit_in is accepted this cycle
//   window_c      : window including the current bit_in (combinational)
//   done_c        : this accept completes a word (combinational)
//   full_c        : this accept leaves at least WIDTH bits in the window (combinational)
module bit_shift_counter
  import z_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] window_c,
  output logic             done_c,
  output logic             full_c
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned FILL_W = $clog2(WIDTH + 1);

  // Only WIDTH-1 history bits are needed: the oldest bit falls out on every shift.
  logic [WIDTH-2:0]  shreg;
  logic [CNT_W-1:0]  bitcnt;
  logic [FILL_W-1:0] fillcnt;
  logic              accept;

  assign accept   = bit_valid & ~clr;
  assign window_c = {shreg, bit_in};
  assign done_c   = accept & (bitcnt == CNT_W'(WIDTH - 1));
  // Counts the current bit too, so the saturated value or one below it qualifies.
  assign full_c   = accept & ((fillcnt == FILL_W'(WIDTH)) |
                              (fillcnt == FILL_W'(WIDTH - 1)));

  // Collection state; never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bitcnt  <= '0;
      fillcnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bitcnt  <= '0;
      fillcnt <= '0;
    end else if (accept) begin
      shreg <= window_c[WIDTH-2:0];
      if (done_c) begin
        bitcnt <= '0;
      end else begin
        bitcnt <= bitcnt + CNT_W'(1);
      end
      if (fillcnt != FILL_W'(WIDTH)) begin
        fillcnt <= fillcnt + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/z_stream_deserializer.sv
// Deserializes the registered z bit stream into WIDTH-bit words, presented on
// a one-entry valid/ready buffer, with a sliding-window pattern detector and a
// sticky overflow flag for dropped words.
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : synchronous flush of all state, wins over bits and handshakes
//   bit_in       : serial data, MSB first
//   bit_valid    : bit_in is accepted this cycle
//   word_out     : buffered completed word
//   word_valid   : word_out holds an untaken word
//   word_ready   : consumer takes the word when word_valid is also 1
//   match_pulse  : one-cycle pulse after an accept whose window equals PATTERN
//   overflow     : sticky, a completed word was dropped while the buffer was full
module z_stream_deserializer
  import z_stream_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             match_pulse,
  output logic             overflow
);

  logic [WIDTH-1:0] window_c;
  logic             done_c;
  logic             full_c;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] word_d;
  logic             match_d;
  logic             ovf_d;

  bit_shift_counter #(
    .WIDTH (WIDTH)
  ) u_collect (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .window_c  (window_c),
    .done_c    (done_c),
    .full_c    (full_c)
  );

  assign word_valid = (state_q == ST_FULL);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      word_out    <= '0;
      match_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_out    <= word_d;
      match_pulse <= match_d;
      overflow    <= ovf_d;
    end
  end

  // Buffer next-state, word load, match detect and overflow.
  always_comb begin
    state_d = state_q;
    word_d  = word_out;
    match_d = 1'b0;
    ovf_d   = overflow;

    if (clr) begin
      state_d = ST_EMPTY;
      word_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      match_d = full_c & (window_c == PATTERN);
      unique case (state_q)
        ST_EMPTY: begin
          if (done_c) begin
            state_d = ST_FULL;
            word_d  = window_c;
          end
        end
        ST_FULL: begin
          if (done_c) begin
            // A same-cycle handshake frees the slot with no bubble.
            if (word_ready) begin
              word_d = window_c;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (word_ready) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/z_stream_deserializer.md
Name: z_stream_deserializer

Overview:
- Downstream consumer of the registered single-bit `z` output of `top_mod`.
- Collects the `z` bit stream, MSB-first, into WIDTH-bit words.
- Offers each completed word on a one-entry valid/ready output buffer.
- Flags a sliding-window pattern match and sticky overflow, for the later RISC-V datapath stages.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- PATTERN, 8'hA5, WIDTH-bit value checked against the last WIDTH accepted bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- clr  in  1  synchronous flush; active high
- bit_in  in  1  serial data (driven by `z`)
- bit_valid  in  1  `bit_in` is accepted this cycle
- word_out  out  WIDTH  buffered completed word
- word_valid  out  1  `word_out` holds an untaken word
- word_ready  in  1  consumer takes the word when `word_valid` is also 1
- match_pulse  out  1  one-cycle pulse on a sliding-window match
- overflow  out  1  sticky; a completed word was dropped

Behaviour:
- Reset (`rst`=0, asynchronous): all outputs and internal state are 0 immediately, including mid-word. The partial word is discarded.
- Accept: on a rising edge with `bit_valid`=1, `shreg <= {shreg[WIDTH-2:0], bit_in}` and `bitcnt` increments.
- Completion: the accept with `bitcnt`==WIDTH-1 completes a word.
  - The completed value is `{shreg[WIDTH-2:0], bit_in}`.
  - `bitcnt` wraps to 0.
  - Collection never stalls.
- Latency: a completed word appears on `word_out` with `word_valid`=1 on the edge that accepts its last bit, i.e. visible the following cycle.
- Buffer state machine, states EMPTY and FULL:
  - EMPTY + completion -> FULL, `word_out` loaded.
  - FULL + (`word_valid` & `word_ready`) with no completion -> EMPTY. `word_out` holds its last value.
  - FULL + handshake + completion in the same cycle -> stays FULL, `word_out` replaced, `word_valid` stays 1 with no bubble.
  - FULL + no handshake + completion -> new word dropped, `word_out` unchanged, `overflow` <= 1.
  - `word_valid` = (state==FULL); `word_out` never changes while FULL without a handshake.
- Match:
  - `fillcnt` saturates at WIDTH and counts accepted bits since reset or `clr`.
  - `match_pulse` is registered. It is 1 for exactly one cycle after any accept where `fillcnt` (including this bit) >= WIDTH and the new window == PATTERN.
  - Match is independent of word alignment; overlapping matches each pulse.
- `clr`:
  - Clears `shreg`, `bitcnt`, `fillcnt`, state, `word_valid`, `match_pulse` and `overflow`. `word_out` is cleared to 0.
  - `clr` wins over a simultaneous `bit_valid` (bit dropped) and over a handshake.
- `word_ready` while EMPTY: ignored.
- `bit_in` while `bit_valid`=0: ignored.
- Width rules:
  - `bitcnt` is $clog2(WIDTH) bits.
  - `fillcnt` is $clog2(WIDTH+1) bits.
  - No other arithmetic.

Decomposition:
- Package `z_stream_pkg`:
  - buffer state enum {ST_EMPTY, ST_FULL}
  - default constants DEF_WIDTH=8, DEF_PATTERN=8'hA5
- One sub-module `bit_shift_counter`:
  - contains `shreg`, `bitcnt`, `fillcnt` and `clr` handling
  - outputs the window, a completion strobe and a window-full flag
- The top level holds the output buffer state machine, the match register and `overflow`.

Test Plan (WIDTH=8, PATTERN=8'hA5):
- Async reset: assert `rst`=0 mid-word (after 5 bits), away from a clock edge -> all outputs 0 immediately. After release, the next 8 bits form a fresh word.
- `word_ready`=1, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> the cycle after the 8th accept shows `word_out`=8'hA5, `word_valid`=1 and `match_pulse`=1. Both clear the next cycle.
- `word_ready`=0, stream 0x3C then 0xC3 (16 bits) -> `word_out` stays 8'h3C, `word_valid` stays 1, `overflow`=1 after bit 16. Later `word_ready`=1 -> `word_valid` drops and `overflow` stays 1.
- `word_ready` raised in the exact cycle word 2 (0x55) completes while word 1 (0x0F) is held -> next cycle `word_out`=8'h55, `word_valid` stays 1, `overflow`=0.
- Unaligned match: bits 0,0,0,0 then A5 MSB-first -> word 1 = 8'h0A after bit 8. `match_pulse` fires only after bit 12. At bit 12 the window is 8'hA5 with `bitcnt` 4.
- `clr`=1 with `bit_valid`=1 after 3 bits -> bit dropped, `overflow`/`word_valid` cleared. The next 8 bits 0xFF give `word_out`=8'hFF with no `match_pulse` before bit 8.
